// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: one-cycle tick every (div+1) clocks plus /2../16 sub-strobes,
// with a glitch-free period change at boundaries and start/stop that never truncates a period.
module clk_en_sched #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DIV_RST = 9
) (
    input  logic             iClkIN,
    input  logic             reset,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iCfgValid,
    input  logic [CNT_W-1:0] iCfgDiv,
    output logic             oCfgReady,
    output logic             oRun,
    output logic             oTick,
    output logic             oDiv2,
    output logic             oDiv4,
    output logic             oDiv8,
    output logic             oDiv16,
    output logic [3:0]       oTickCnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic             tick_q, tick_d;
    logic             div2_q, div2_d;
    logic             div4_q, div4_d;
    logic             div8_q, div8_d;
    logic             div16_q, div16_d;
    logic             ready_q, ready_d;
    logic             cfg_fire;

    assign cfg_fire = iCfgValid & ready_q;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        tick_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    div_d = iCfgDiv;
                end
                if (iStart && !iStop) begin
                    state_d = StRun;
                    cnt_d   = cfg_fire ? iCfgDiv : div_q;
                    tcnt_d  = 4'd0;
                end
            end
            StRun, StDrain: begin
                // Ready is ~pend here, so an accept never collides with a pending apply.
                if (cfg_fire) begin
                    shadow_d = iCfgDiv;
                    pend_d   = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (state_q == StRun && iStop) begin
                        state_d = StDrain;
                    end
                end else begin
                    tick_d = 1'b1;
                    tcnt_d = tcnt_q + 4'd1;
                    if (pend_q) begin
                        cnt_d  = shadow_q;
                        div_d  = shadow_q;
                        pend_d = 1'b0;
                    end else begin
                        cnt_d = div_q;
                    end
                    if (state_q == StDrain || iStop) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        div2_d  = tick_d && (tcnt_d[0] == 1'b0);
        div4_d  = tick_d && (tcnt_d[1:0] == 2'd0);
        div8_d  = tick_d && (tcnt_d[2:0] == 3'd0);
        div16_d = tick_d && (tcnt_d == 4'd0);
        ready_d = (state_d == StIdle) ? 1'b1 : ~pend_d;
    end

    always_ff @(posedge iClkIN) begin
        if (!reset) begin
            state_q  <= StIdle;
            div_q    <= CNT_W'(DIV_RST);
            shadow_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            tcnt_q   <= 4'd0;
            tick_q   <= 1'b0;
            div2_q   <= 1'b0;
            div4_q   <= 1'b0;
            div8_q   <= 1'b0;
            div16_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            tick_q   <= tick_d;
            div2_q   <= div2_d;
            div4_q   <= div4_d;
            div8_q   <= div8_d;
            div16_q  <= div16_d;
            ready_q  <= ready_d;
        end
    end

    assign oCfgReady = ready_q;
    assign oRun      = (state_q != StIdle);
    assign oTick     = tick_q;
    assign oDiv2     = div2_q;
    assign oDiv4     = div4_q;
    assign oDiv8     = div8_q;
    assign oDiv16    = div16_q;
    assign oTickCnt  = tcnt_q;

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed bench for clk_en_sched; edge numbers count from the edge that samples iStart.
module tb_clk_en_sched;

    logic       iClkIN = 1'b0;
    logic       reset;
    logic       iStart;
    logic       iStop;
    logic       iCfgValid;
    logic [7:0] iCfgDiv;
    logic       oCfgReady;
    logic       oRun;
    logic       oTick;
    logic       oDiv2;
    logic       oDiv4;
    logic       oDiv8;
    logic       oDiv16;
    logic [3:0] oTickCnt;

    int checks   = 0;
    int failures = 0;
    int t;
    int tkc;
    bit tk;

    clk_en_sched #(
        .CNT_W   (8),
        .DIV_RST (9)
    ) dut (
        .iClkIN    (iClkIN),
        .reset     (reset),
        .iStart    (iStart),
        .iStop     (iStop),
        .iCfgValid (iCfgValid),
        .iCfgDiv   (iCfgDiv),
        .oCfgReady (oCfgReady),
        .oRun      (oRun),
        .oTick     (oTick),
        .oDiv2     (oDiv2),
        .oDiv4     (oDiv4),
        .oDiv8     (oDiv8),
        .oDiv16    (oDiv16),
        .oTickCnt  (oTickCnt)
    );

    always #5 iClkIN = ~iClkIN;

    task automatic step();
        @(posedge iClkIN);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; iStart = 1'b0; iStop = 1'b0; iCfgValid = 1'b0; iCfgDiv = 8'd0;
        step();
        step();
        chk("rst_run", oRun, 0);
        chk("rst_tick", oTick, 0);
        chk("rst_div16", oDiv16, 0);
        chk("rst_tcnt", oTickCnt, 0);
        chk("rst_ready", oCfgReady, 0);
        reset = 1'b1;
        step();
        chk("idle_ready", oCfgReady, 1);
        chk("idle_run", oRun, 0);

        // D=9 from reset, 17 ticks, stop sampled 4 edges into the 17th period
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        chk("t1_run0", oRun, 1);
        chk("t1_tick0", oTick, 0);
        for (int n = 1; n <= 170; n++) begin
            iStop = (n == 164);
            step();
            t  = n / 10;
            tk = (n % 10) == 0;
            chk("t1_tick", oTick, tk);
            chk("t1_div2", oDiv2, tk && (t % 2 == 0));
            chk("t1_div4", oDiv4, tk && (t % 4 == 0));
            chk("t1_div8", oDiv8, tk && (t % 8 == 0));
            chk("t1_div16", oDiv16, tk && (t % 16 == 0));
            chk("t1_tcnt", oTickCnt, t % 16);
            chk("t1_run", oRun, n < 170);
        end
        iStop = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step();
            chk("t1_post_tick", oTick, 0);
            chk("t1_post_run", oRun, 0);
            chk("t1_post_tcnt", oTickCnt, 1);
        end
        iStart = 1'b1; iStop = 1'b1;
        step();
        chk("both_run", oRun, 0);
        iStart = 1'b0; iStop = 1'b0;
        step();
        chk("both_run2", oRun, 0);
        chk("both_tick", oTick, 0);

        // D=0: tick every cycle
        iCfgValid = 1'b1; iCfgDiv = 8'd0;
        step();
        iCfgValid = 1'b0;
        chk("t2_ready", oCfgReady, 1);
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        chk("t2_run0", oRun, 1);
        chk("t2_tcnt0", oTickCnt, 0);
        for (int n = 1; n <= 20; n++) begin
            step();
            chk("t2_tick", oTick, 1);
            chk("t2_tcnt", oTickCnt, n % 16);
            chk("t2_div2", oDiv2, n % 2 == 0);
            chk("t2_div4", oDiv4, n % 4 == 0);
            chk("t2_div16", oDiv16, n % 16 == 0);
        end
        iStop = 1'b1;
        step();
        iStop = 1'b0;
        chk("t2_stop_tick", oTick, 1);
        chk("t2_stop_run", oRun, 0);
        chk("t2_stop_tcnt", oTickCnt, 5);
        step();
        chk("t2_idle_tick", oTick, 0);

        // D=9, config 3 accepted at edge 4, a second offer of 7 held off until the boundary
        iCfgValid = 1'b1; iCfgDiv = 8'd9;
        step();
        iCfgValid = 1'b0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        tkc = 0;
        for (int n = 1; n <= 26; n++) begin
            iCfgValid = (n >= 4) && (n <= 10);
            iCfgDiv   = (n == 4) ? 8'd3 : 8'd7;
            iStop     = (n == 23);
            step();
            tk = (n == 10) || ((n > 10) && ((n - 10) % 4 == 0));
            if (tk) tkc++;
            chk("t3_tick", oTick, tk);
            chk("t3_ready", oCfgReady, !((n >= 4) && (n <= 9)));
            chk("t3_tcnt", oTickCnt, tkc % 16);
            chk("t3_run", oRun, n < 26);
        end
        iCfgValid = 1'b0; iStop = 1'b0;
        step();
        chk("t3_idle_tick", oTick, 0);
        chk("t3_idle_run", oRun, 0);

        // reset mid-period restores DIV_RST over a configured 5
        iCfgValid = 1'b1; iCfgDiv = 8'd5;
        step();
        iCfgValid = 1'b0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            chk("t4_pre_tick", oTick, 0);
            chk("t4_pre_run", oRun, 1);
        end
        reset = 1'b0;
        step();
        chk("t4_rst_run", oRun, 0);
        chk("t4_rst_tick", oTick, 0);
        chk("t4_rst_tcnt", oTickCnt, 0);
        chk("t4_rst_ready", oCfgReady, 0);
        chk("t4_rst_div2", oDiv2, 0);
        step();
        chk("t4_rst_tick2", oTick, 0);
        chk("t4_rst_ready2", oCfgReady, 0);
        reset = 1'b1;
        step();
        chk("t4_idle_ready", oCfgReady, 1);
        chk("t4_idle_run", oRun, 0);
        chk("t4_idle_tick", oTick, 0);
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            iStop = (n == 11);
            step();
            chk("t4_tick", oTick, (n == 10) || (n == 20));
            chk("t4_tcnt", oTickCnt, n / 10);
            chk("t4_run", oRun, n < 20);
        end
        iStop = 1'b0;
        step();
        chk("t4_end_run", oRun, 0);

        // config 2 accepted in the start cycle
        iCfgValid = 1'b1; iCfgDiv = 8'd2; iStart = 1'b1;
        step();
        iCfgValid = 1'b0; iStart = 1'b0;
        chk("t5_run0", oRun, 1);
        for (int n = 1; n <= 6; n++) begin
            step();
            chk("t5_tick", oTick, n % 3 == 0);
            chk("t5_tcnt", oTickCnt, n / 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
